// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one BRAM port between the core (fixed priority) and secondary master m1; optional starvation guard under AYATSUKI_ARB_STARVE_GUARD_EN.
// Latency: grant and memory strobes are combinational in the request cycle; m1 read data and m1_rvalid_o follow one cycle later.
// Backpressure: m1 holds its level request while the core is busy; with the guard, a forced slot stalls the core through m0_hold_o.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_r_enable_i,
  input  logic              m0_w_enable_i,
  input  logic [ADDR_W-1:0] m0_r_addr_i,
  input  logic [ADDR_W-1:0] m0_w_addr_i,
  input  logic [DATA_W-1:0] m0_w_data_i,
  output logic [DATA_W-1:0] m0_r_data_o,
  output logic              m0_hold_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              mem_w_enable_o,
  output logic              mem_r_enable_o,
  output logic              mem_enable_o,
  output logic [ADDR_W-1:0] mem_w_addr_o,
  output logic [ADDR_W-1:0] mem_r_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  typedef struct packed {
    logic              r_en;
    logic              w_en;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_dat;
  } mem_req_t;

  localparam logic [0:0] ARB_CORE  = 1'b0;
  localparam logic [0:0] ARB_FORCE = 1'b1;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be within 1..255");
  end

  logic              core_busy;
  logic              force_slot;
  logic              m1_sel;
  mem_req_t          port;
  logic              rd_m1_q, rd_m1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  assign core_busy = m0_r_enable_i | m0_w_enable_i;

`ifdef AYATSUKI_ARB_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT - 1);

  logic [0:0] state_q, state_d;
  logic [7:0] starve_q, starve_d;

  assign force_slot = (state_q == ARB_FORCE);

  // The forced slot lasts one cycle; the counter only runs while m1 is denied in ARB_CORE.
  always_comb begin
    state_d  = ARB_CORE;
    starve_d = starve_q;
    if (!m1_req_i || m1_sel) begin
      starve_d = '0;
    end else if (core_busy && !force_slot) begin
      if (starve_q == STARVE_MAX) begin
        state_d  = ARB_FORCE;
        starve_d = '0;
      end else begin
        starve_d = starve_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_CORE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end
`else
  assign force_slot = 1'b0;
`endif

  assign m1_sel = force_slot | (~core_busy & m1_req_i);

  // Core addresses pass through when m1 does not own that side of the port.
  always_comb begin
    port        = '0;
    port.r_addr = m0_r_addr_i;
    port.w_addr = m0_w_addr_i;
    port.w_dat  = m0_w_data_i;
    if (m1_sel) begin
      port.r_en = ~m1_we_i;
      port.w_en = m1_we_i;
      if (m1_we_i) begin
        port.w_addr = m1_addr_i;
        port.w_dat  = m1_wdata_i;
      end else begin
        port.r_addr = m1_addr_i;
      end
    end else begin
      port.r_en = m0_r_enable_i;
      port.w_en = m0_w_enable_i;
    end
  end

  assign mem_r_enable_o = port.r_en;
  assign mem_w_enable_o = port.w_en;
  assign mem_enable_o   = port.r_en | port.w_en;
  assign mem_r_addr_o   = port.r_addr;
  assign mem_w_addr_o   = port.w_addr;
  assign mem_data_o     = port.w_dat;

  assign m1_gnt_o    = m1_sel;
  assign m0_hold_o   = force_slot;
  assign m0_r_data_o = mem_data_i;

  // BRAM data is live in the rvalid cycle; the register keeps it stable afterwards.
  assign rd_m1_d = m1_sel & ~m1_we_i;
  assign rdata_d = rd_m1_q ? mem_data_i : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_m1_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      rd_m1_q <= rd_m1_d;
      rdata_q <= rdata_d;
    end
  end

  assign m1_rvalid_o = rd_m1_q;
  assign m1_rdata_o  = rdata_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed stimulus against a cycle-level reference model with a read-data scoreboard.
// Honours AYATSUKI_ARB_STARVE_GUARD_EN for the expected starvation behaviour.
module tb_mem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 8;
`ifdef AYATSUKI_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_r_enable_i = 1'b0, m0_w_enable_i = 1'b0;
  logic [AW-1:0] m0_r_addr_i = '0, m0_w_addr_i = '0;
  logic [DW-1:0] m0_w_data_i = '0;
  logic [DW-1:0] m0_r_data_o;
  logic          m0_hold_o;
  logic          m1_req_i = 1'b0, m1_we_i = 1'b0;
  logic [AW-1:0] m1_addr_i = '0;
  logic [DW-1:0] m1_wdata_i = '0;
  logic          m1_gnt_o, m1_rvalid_o;
  logic [DW-1:0] m1_rdata_o;
  logic          mem_w_enable_o, mem_r_enable_o, mem_enable_o;
  logic [AW-1:0] mem_w_addr_o, mem_r_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [DW-1:0] mem_data_i;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_r_enable_i(m0_r_enable_i), .m0_w_enable_i(m0_w_enable_i),
    .m0_r_addr_i(m0_r_addr_i), .m0_w_addr_i(m0_w_addr_i), .m0_w_data_i(m0_w_data_i),
    .m0_r_data_o(m0_r_data_o), .m0_hold_o(m0_hold_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .mem_w_enable_o(mem_w_enable_o), .mem_r_enable_o(mem_r_enable_o), .mem_enable_o(mem_enable_o),
    .mem_w_addr_o(mem_w_addr_o), .mem_r_addr_o(mem_r_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i)
  );

  // Environment BRAM: 16 words, 1-cycle read latency, read-before-write.
  logic [DW-1:0] bram [16];
  always @(posedge clk) begin
    if (mem_r_enable_o) mem_data_i <= bram[mem_r_addr_o[5:2]];
    if (mem_w_enable_o) bram[mem_w_addr_o[5:2]] <= mem_data_o;
  end

  typedef struct {
    int            cyc;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [16];
  int            denied = 0;
  bit            force_next = 1'b0;
  bit            m0_exp_vld = 1'b0;
  logic [DW-1:0] m0_exp_dat = '0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive, predict from the arbitration rules, compare at the falling edge.
  task automatic step(input bit r, input bit w, input logic [31:0] ra, input logic [31:0] wa,
                      input logic [31:0] wd, input bit req, input bit we,
                      input logic [31:0] ma, input logic [31:0] md, output bit granted);
    bit            busy, forced, g, chk_m0;
    logic [DW-1:0] m0_dat;
    @(posedge clk);
    #1;
    cyc++;
    m0_r_enable_i = r;  m0_w_enable_i = w;
    m0_r_addr_i   = ra; m0_w_addr_i   = wa; m0_w_data_i = wd;
    m1_req_i      = req; m1_we_i = we; m1_addr_i = ma; m1_wdata_i = md;
    chk_m0 = m0_exp_vld;
    m0_dat = m0_exp_dat;
    busy   = r | w;
    forced = force_next & GUARD;
    g      = forced | (~busy & req);
    force_next = 1'b0;
    if (!req || g) denied = 0;
    else if (busy) begin
      denied++;
      if (denied == LIMIT) begin
        force_next = 1'b1;
        denied     = 0;
      end
    end
    @(negedge clk);
    check("strobes", {59'd0, m1_gnt_o, m0_hold_o, mem_r_enable_o, mem_w_enable_o, mem_enable_o},
          {59'd0, g, forced, (g ? ~we : r), (g ? we : w), (g | r | w)});
    if (g ? !we : r) check("r_addr", {32'd0, mem_r_addr_o}, {32'd0, (g ? ma : ra)});
    if (g ? we : w)  check("w_addr_dat", {mem_w_addr_o, mem_data_o}, (g ? {ma, md} : {wa, wd}));
    if (chk_m0) check("m0_rdata", {32'd0, m0_r_data_o}, {32'd0, m0_dat});
    m0_exp_vld = !g && r;
    if (!g && r) m0_exp_dat = ref_mem[ra[5:2]];
    if (g && !we) exp_q.push_back('{cyc: cyc, dat: ref_mem[ma[5:2]]});
    if (g && we) ref_mem[ma[5:2]] = md;
    else if (!g && w) ref_mem[wa[5:2]] = wd;
    granted = g;
  endtask

  // Scoreboard monitor: every rvalid pops the oldest expected read.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m1_rvalid_o) begin
        if (exp_q.size() == 0) check("rvalid_spurious", {63'd0, m1_rvalid_o}, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("rvalid_cycle", 64'(cyc), 64'(e.cyc + 1));
          check("m1_rdata", {32'd0, m1_rdata_o}, {32'd0, e.dat});
        end
      end
      while (exp_q.size() != 0 && exp_q[0].cyc + 1 < cyc) begin
        check("rvalid_missing", 64'(cyc), 64'(exp_q[0].cyc + 1));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit            g, pend, twe, r, w;
    logic [31:0]   tad, tdat, ra, wa;
    int            ngnt, nhold, first;
    pend = 1'b0; twe = 1'b0; tad = '0; tdat = '0;

    #3;
    check("reset_flags", {60'd0, m1_rvalid_o, m0_hold_o, m1_gnt_o, mem_enable_o}, 64'd0);
    check("reset_rdata", {32'd0, m1_rdata_o}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      step(0, 1, 0, 32'(i * 4), $urandom, 0, 0, 0, 0, g);

    // Idle core, m1 read of a known word.
    step(0, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, g);
    step(0, 0, 0, 0, 0, 1, 0, 32'h10, 0, g);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);

    // Core read collides with m1 write; m1 goes in the next idle cycle.
    step(1, 0, 32'h20, 0, 0, 1, 1, 32'h14, 32'hA5A55A5A, g);
    step(0, 0, 0, 0, 0, 1, 1, 32'h14, 32'hA5A55A5A, g);
    step(0, 0, 0, 0, 0, 1, 0, 32'h14, 0, g);

    // Back-to-back m1 reads.
    step(0, 0, 0, 0, 0, 1, 0, 32'h0, 0, g);
    step(0, 0, 0, 0, 0, 1, 0, 32'h4, 0, g);
    step(0, 0, 0, 0, 0, 1, 0, 32'h8, 0, g);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);

    // Continuously busy core with m1 requesting.
    ngnt = 0; nhold = 0; first = -1;
    for (int i = 0; i < LIMIT + 1; i++) begin
      step(1, 0, 32'(i * 4), 0, 0, 1, 0, 32'h24, 0, g);
      if (g) begin ngnt++; first = i; end
      nhold += int'(m0_hold_o);
    end
    check("starve_gnt_cnt", 64'(ngnt), 64'(GUARD ? 1 : 0));
    check("starve_hold_cnt", 64'(nhold), 64'(GUARD ? 1 : 0));
    check("starve_gnt_slot", 64'(first), 64'(GUARD ? LIMIT : -1));
    step(1, 0, 32'h28, 0, 0, 0, 0, 0, 0, g);

    // Reset right after an m1 read grant.
    step(0, 0, 0, 0, 0, 1, 0, 32'h8, 0, g);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    m0_r_enable_i = 1'b0; m0_w_enable_i = 1'b0; m1_req_i = 1'b0;
    exp_q.delete();
    denied = 0; force_next = 1'b0; m0_exp_vld = 1'b0;
    @(negedge clk);
    check("midrst_flags", {61'd0, m1_rvalid_o, m0_hold_o, m1_gnt_o}, 64'd0);
    check("midrst_rdata", {32'd0, m1_rdata_o}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 0, 32'h4, 0, 0, 1, 0, 32'hC, 0, g);
    step(0, 0, 0, 0, 0, 1, 0, 32'hC, 0, g);

    // Randomized traffic with busy-heavy phases to exercise starvation.
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 99) < (((c / 200) % 2 == 1) ? 90 : 45));
      w = ($urandom_range(0, 99) < 25);
      ra = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      wa = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if (!pend && $urandom_range(0, 99) < 40) begin
        pend = 1'b1;
        twe  = 1'($urandom_range(0, 1));
        tad  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        tdat = $urandom;
      end else if (pend && !(force_next && GUARD) && $urandom_range(0, 99) < 5) begin
        pend = 1'b0;
      end
      step(r, w, ra, wa, $urandom, pend, twe, tad, tdat, g);
      if (g) pend = 1'b0;
    end

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
    check("rvalid_drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single data-memory (BRAM) port between the core's load/store path and one secondary bus master, such as a boot loader or DMA engine. It sits between the core's data-memory outputs and the BRAM. The core has fixed priority. The secondary master gets idle cycles and, optionally, a forced slot that stalls the core pipeline through `ctrl`. The block routes the 1-cycle-latency BRAM read data back to whichever master issued the read.

## Interface
Parameters:
- `ADDR_W`, 32, address width of both masters and the memory port
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 8, consecutive denied m1 cycles before a forced grant (only with macro; legal range 1..255)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `m0_r_enable_i`  in  1  core read request, issued in EX
- `m0_w_enable_i`  in  1  core write request, issued in MEM/WB
- `m0_r_addr_i`  in  ADDR_W  core read address
- `m0_w_addr_i`  in  ADDR_W  core write address
- `m0_w_data_i`  in  DATA_W  core write data
- `m0_r_data_o`  out  DATA_W  core read data; continuous copy of `mem_data_i`
- `m0_hold_o`  out  1  stall request to `ctrl`; core must re-present its access next cycle
- `m1_req_i`  in  1  secondary access request, level, held until granted
- `m1_we_i`  in  1  1 = write, 0 = read
- `m1_addr_i`  in  ADDR_W  secondary address
- `m1_wdata_i`  in  DATA_W  secondary write data
- `m1_gnt_o`  out  1  access issued to memory this cycle
- `m1_rvalid_o`  out  1  `m1_rdata_o` valid (pulse, 1 cycle after a granted read)
- `m1_rdata_o`  out  DATA_W  registered-path read data for m1
- `mem_w_enable_o`, `mem_r_enable_o`, `mem_enable_o`  out  1 each  memory port strobes
- `mem_w_addr_o`, `mem_r_addr_o`  out  ADDR_W  memory port addresses
- `mem_data_o`  out  DATA_W  memory write data
- `mem_data_i`  in  DATA_W  BRAM read data, valid 1 cycle after the read strobe

## Operation
- States: `ARB_CORE` (reset) and `ARB_FORCE`.
- In `ARB_CORE`, define `core_busy = m0_r_enable_i | m0_w_enable_i`.
  - `core_busy`=1: the core drives the memory port unchanged (read and write may coincide). `m1_gnt_o`=0.
  - `core_busy`=0 and `m1_req_i`=1: m1 drives the port. Use `mem_w_*` if `m1_we_i`=1, else `mem_r_*`. `m1_gnt_o`=1.
  - Otherwise: all strobes are 0.
- In `ARB_FORCE`:
  - m1 drives the port, `m1_gnt_o`=1, `m0_hold_o`=1.
  - Core strobes are masked regardless of their value.
  - The next state is `ARB_CORE` unconditionally.
- Starvation counter `starve_q` (8 bit):
  - Increments in cycles where `m1_req_i` & `core_busy` & state=`ARB_CORE`.
  - Clears on any `m1_gnt_o`, and whenever `m1_req_i`=0.
  - When `starve_q` = STARVE_LIMIT-1 and it would increment, the next state is `ARB_FORCE` and `starve_q` clears.
- `mem_enable_o` = `mem_w_enable_o` | `mem_r_enable_o`.
- Read owner register `rd_m1_q`: set to 1 on the cycle m1 is granted a read, else 0. `m1_rvalid_o` = `rd_m1_q`.
- `m1_rdata_o`: captured from `mem_data_i` one cycle after the read, exposed together with `m1_rvalid_o`.
- m1 write with `m1_we_i`=1 produces no `m1_rvalid_o`.
- Reset mid-operation: an outstanding m1 read is dropped, no `m1_rvalid_o` is produced, and the state returns to `ARB_CORE`.

## Timing
- Grant is combinational in the request cycle; the memory strobe appears in the same cycle as `m1_gnt_o`.
- m1 read latency: `m1_rvalid_o` is asserted exactly 1 cycle after the `m1_gnt_o` cycle. Back-to-back m1 reads are allowed, giving one rvalid per cycle.
- `m0_hold_o` is high only in `ARB_FORCE`, for exactly 1 cycle per forced grant. It is entered on the clock edge after the limit is reached.
- Reset values:
  - `starve_q`=0, state=`ARB_CORE`, `rd_m1_q`=0.
  - `m1_rvalid_o`=0, `m1_rdata_o`=0, `m0_hold_o`=0, `m1_gnt_o`=0.
  - Memory strobes follow the combinational rules with state=`ARB_CORE`.
- Simultaneous m1 request and core access in `ARB_CORE`: the core wins.
- `m1_req_i` dropping before grant is legal and clears `starve_q`.

## Configuration
- `AYATSUKI_ARB_STARVE_GUARD_EN` defined:
  - `starve_q`, `ARB_FORCE` and `m0_hold_o` are implemented as above.
- Undefined:
  - There is no counter and no `ARB_FORCE`.
  - `m0_hold_o` is tied to 0, so m1 is served only in core-idle cycles and may starve indefinitely.
  - `STARVE_LIMIT` is ignored.

## Test plan
- Idle core; m1 read at addr 0x10 with BRAM content 0xDEADBEEF → `m1_gnt_o`=1 in cycle t, `mem_r_addr_o`=0x10 at t; `m1_rvalid_o`=1 and `m1_rdata_o`=0xDEADBEEF at t+1.
- Core read at 0x20 and m1 write in the same cycle → core address on port, `m1_gnt_o`=0. In the next idle cycle m1 write issues with `mem_w_enable_o`=1.
- Core continuously busy with m1 requesting, STARVE_LIMIT=8, guard on → 8 denied cycles, then 1 cycle with `m0_hold_o`=1, `m1_gnt_o`=1 and core strobes masked. Then core access resumes.
- Same as previous with guard off → `m1_gnt_o` and `m0_hold_o` remain 0 throughout.
- m1 reads at 0x0, 0x4, 0x8 back-to-back with idle core → three consecutive `m1_rvalid_o` pulses carrying the data in order.
- `rst_n` asserted the cycle after an m1 read grant → no `m1_rvalid_o`, all registered outputs are 0, and the state is `ARB_CORE`.
